spi_cmd_ctrl: RTL
=================

Name: spi_cmd_ctrl

Overview:
Command sequencer behind the SPI_slave byte engine in the beamScanner configuration path. Parses SPI frames into register-bank accesses:
- first byte of a frame is the command: bit7 = read, bits6:0 = start address
- following bytes are write data or read-data slots, with address auto-increment

It also supplies the next transmit byte and transmit enable back to SPI_slave. It runs entirely on the system clock and synchronises the SPI-side signals internally.

Parameters:
NUM_REGS, 32, number of implemented registers (1..128); addresses at or above it are out of range.
MLB, 1, bit order driven to SPI_slave mlb (1 = MSB first).
SYNC_STAGES, 2, flop count of the ss/done synchronisers (≥2).

Ports:
clk  in  1  system clock; all logic is rising-edge.
rst  in  1  synchronous active-high reset.
ss  in  1  SPI slave select from pin, active-low, asynchronous to clk.
spi_done  in  1  SPI_slave done, sck domain, high after each 8th bit.
spi_rdata  in  8  SPI_slave received byte, stable while spi_done high.
spi_ten  out  1  transmit enable to SPI_slave.
spi_tdata  out  8  transmit byte to SPI_slave.
spi_mlb  out  1  bit order to SPI_slave; constant equal to MLB.
reg_wr  out  1  one-clk register write strobe.
reg_rd  out  1  one-clk register read strobe.
reg_addr  out  7  register address for reg_wr/reg_rd.
reg_wdata  out  8  write data, valid with reg_wr.
reg_rdata  in  8  read data, valid the clk after reg_rd.
busy  out  1  high whenever state ≠ IDLE.
frame_err  out  1  sticky out-of-range flag.

Behaviour:
- Synchronisation: ss and spi_done each pass through SYNC_STAGES flops.
  - byte_stb = rising edge of synced done.
  - frm_start = falling edge of synced ss; frm_end = rising edge of synced ss.
  - spi_rdata is sampled on byte_stb (quasi-static by construction).
- Reset values: spi_ten=0, spi_tdata=0x00, reg_wr=0, reg_rd=0, reg_addr=0, reg_wdata=0, busy=0, frame_err=0, state=IDLE (or WAIT_END, see below).
- States: IDLE, CMD, FETCH, LOAD, DATA, WAIT_END.
- IDLE: on frm_start go to CMD; spi_tdata=0x00, spi_ten=1.
- CMD: on byte_stb latch rw=rdata[7], addr=rdata[6:0].
  - rw=1: go to FETCH.
  - rw=0: go to DATA.
- FETCH: if addr<NUM_REGS, pulse reg_rd with reg_addr=addr. Go to LOAD.
- LOAD: spi_tdata = reg_rdata if in range, else 0x00. Go to DATA.
  - Read latency from byte_stb to spi_tdata valid: 3 clk.
  - Requirement: clk ≥ 8× sck so spi_tdata is updated before the next byte's first bit.
- DATA, write: on byte_stb, if addr<NUM_REGS pulse reg_wr (reg_addr=addr, reg_wdata=spi_rdata), else set frame_err and suppress reg_wr. Then addr increments.
- DATA, read: on byte_stb, addr increments and the FSM goes to FETCH.
- Address increment: wraps NUM_REGS-1 → 0. Out-of-range start addresses increment to 127 then wrap to 0.
- frm_end in any state except IDLE: go to IDLE, spi_ten=0. A partial byte is discarded.
- byte_stb and frm_end in the same clk: the byte is processed first (write strobe issued), then the FSM goes to IDLE.
- frm_start while not in IDLE cannot occur; it is ignored.
- Reset asserted mid-frame: outputs take reset values. If synced ss is low after reset, the FSM enters WAIT_END and ignores all byte_stb until frm_end, then returns to IDLE.
- frame_err is cleared only by rst.

Optional Feature:
Macro SPI_CMD_WR_ECHO_EN.
- Defined: during write bursts, each byte_stb loads spi_tdata with the byte just received, so the master reads back its own previous byte (command byte echoed in the first data slot).
- Undefined: spi_tdata holds 0x00 during write frames.

Decomposition:
- Package spi_cmd_pkg:
  - state enum
  - RW_BIT=7
  - ADDR_W=7
  - IDLE_TDATA=8'h00
- Sub-module spi_cmd_sync (SYNC_STAGES flop chain plus rise/fall edge detect), instantiated twice: for ss and for spi_done.

Test Plan:
- Frame 0x05,0xA5 → exactly one reg_wr, addr 0x05, data 0xA5; frame_err=0.
- Burst write 0x1F,0x11,0x22 with NUM_REGS=32 → reg_wr addr 0x1F/0x11 then addr 0x00/0x22.
- Read 0x83 with reg_rdata=0x5C → reg_rd addr 0x03; spi_tdata=0x5C within 3 clk of byte_stb; spi_ten=1; second read slot fetches addr 0x04.
- Write 0x40,0xFF with NUM_REGS=32 → no reg_wr; frame_err=1 and stays 1 until rst.
- ss rises after 4 sck of the data byte → no reg_wr, state=IDLE, spi_ten=0; byte_stb coincident with frm_end → write still issued.
- rst pulse mid-frame with ss low → no strobes until ss high; the next frame 0x02,0x33 writes normally; echo checked with SPI_CMD_WR_ECHO_EN defined and undefined.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// Shared constants, FSM state encodings and the address-advance helper for the SPI command sequencer.
package spi_cmd_pkg;

   localparam int        RW_BIT     = 7;
   localparam int        ADDR_W     = 7;
   localparam logic [7:0] IDLE_TDATA = 8'h00;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_CMD      = 3'd1;
   localparam state_t ST_FETCH    = 3'd2;
   localparam state_t ST_LOAD     = 3'd3;
   localparam state_t ST_DATA     = 3'd4;
   localparam state_t ST_WAIT_END = 3'd5;

   // The last implemented register wraps to 0; out-of-range addresses run on to 127 and wrap naturally.
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                   input logic [ADDR_W:0]   num_regs);
      if ({1'b0, a} == num_regs - 1'b1)
         return '0;
      return a + 1'b1;
   endfunction

endpackage

// File: rtl/spi_cmd_sync.sv
// Multi-flop synchroniser for one asynchronous level, with rise/fall pulses of the synchronised level.
module spi_cmd_sync
   import spi_cmd_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              prev;

   // No reset: after rst the chain already mirrors the pin, so no false edge is seen.
   always_ff @(posedge clk) begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
   end

   assign level = chain[STAGES-1];
   assign rise  = level & ~prev;
   assign fall  = ~level & prev;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI frame to register-bank command sequencer (command byte, then auto-incrementing data bytes).
// Optional build macro SPI_CMD_WR_ECHO_EN: echo each received write byte back on spi_tdata.
module spi_cmd_ctrl
   import spi_cmd_pkg::*;
#(
   parameter int NUM_REGS    = 32,
   parameter bit MLB         = 1'b1,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ss,
   input  logic              spi_done,
   input  logic [7:0]        spi_rdata,
   output logic              spi_ten,
   output logic [7:0]        spi_tdata,
   output logic              spi_mlb,
   output logic              reg_wr,
   output logic              reg_rd,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [7:0]        reg_wdata,
   input  logic [7:0]        reg_rdata,
   output logic              busy,
   output logic              frame_err
);

   localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);

   logic              ss_lvl, frm_start, frm_end;
   logic              done_lvl, byte_stb, done_fall;
   state_t            state;
   logic              rw;
   logic [ADDR_W-1:0] addr, nxt, cmd_addr;
   logic              addr_ok, nxt_ok, cmd_ok;

   spi_cmd_sync #(.STAGES(SYNC_STAGES)) u_ss_sync (
      .clk(clk), .din(ss), .level(ss_lvl), .rise(frm_end), .fall(frm_start)
   );

   spi_cmd_sync #(.STAGES(SYNC_STAGES)) u_done_sync (
      .clk(clk), .din(spi_done), .level(done_lvl), .rise(byte_stb), .fall(done_fall)
   );

   assign cmd_addr = spi_rdata[ADDR_W-1:0];
   assign nxt      = next_addr(addr, NREGS);
   assign addr_ok  = {1'b0, addr} < NREGS;
   assign nxt_ok   = {1'b0, nxt} < NREGS;
   assign cmd_ok   = {1'b0, cmd_addr} < NREGS;
   assign spi_mlb  = MLB;
   assign busy     = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         // A frame still in progress after reset is ridden out in WAIT_END.
         state     <= ss_lvl ? ST_IDLE : ST_WAIT_END;
         spi_ten   <= 1'b0;
         spi_tdata <= IDLE_TDATA;
         reg_wr    <= 1'b0;
         reg_rd    <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         frame_err <= 1'b0;
         rw        <= 1'b0;
         addr      <= '0;
      end else begin
         reg_wr <= 1'b0;
         reg_rd <= 1'b0;
         case (state)
            ST_IDLE: if (frm_start) begin
               state     <= ST_CMD;
               spi_tdata <= IDLE_TDATA;
               spi_ten   <= 1'b1;
            end
            ST_CMD: if (byte_stb) begin
               rw   <= spi_rdata[RW_BIT];
               addr <= cmd_addr;
               if (spi_rdata[RW_BIT]) begin
                  // Read strobe is issued during FETCH so reg_rdata is ready in LOAD.
                  reg_rd   <= cmd_ok;
                  reg_addr <= cmd_addr;
                  state    <= ST_FETCH;
               end else begin
                  state <= ST_DATA;
`ifdef SPI_CMD_WR_ECHO_EN
                  spi_tdata <= spi_rdata;
`endif
               end
            end
            ST_FETCH: state <= ST_LOAD;
            ST_LOAD: begin
               spi_tdata <= addr_ok ? reg_rdata : IDLE_TDATA;
               state     <= ST_DATA;
            end
            ST_DATA: if (byte_stb) begin
               addr <= nxt;
               if (rw) begin
                  reg_rd   <= nxt_ok;
                  reg_addr <= nxt;
                  state    <= ST_FETCH;
               end else begin
                  if (addr_ok) begin
                     reg_wr    <= 1'b1;
                     reg_addr  <= addr;
                     reg_wdata <= spi_rdata;
                  end else begin
                     frame_err <= 1'b1;
                  end
`ifdef SPI_CMD_WR_ECHO_EN
                  spi_tdata <= spi_rdata;
`endif
               end
            end
            default: ;
         endcase
         // Frame end wins over any state change above; a byte in the same clk is still committed.
         if (frm_end && state != ST_IDLE) begin
            state   <= ST_IDLE;
            spi_ten <= 1'b0;
         end
      end
   end

endmodule
